// File: rtl/vga_ram_arbiter_if.sv
// Purpose : bundles the display-fetch, host-bus and video-RAM signals of the arbiter.
// Latency : none (wiring only).
// Backpressure: none; requesters see drops through disp_ovf / bus_err.
//
// Port summary
//   display : disp_stb, disp_addr -> disp_data, disp_valid, disp_ovf
//   host bus: bus_stb, bus_rnw, bus_addr, bus_wdata -> bus_rdata, bus_ack, bus_err
//   RAM     : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
// master = requesters plus the RAM model, slave = the arbiter.
`timescale 1ns/1ps
interface vga_ram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    // display fetch port
    logic          disp_stb;
    logic [0:AW-1] disp_addr;
    logic [0:DW-1] disp_data;
    logic          disp_valid;
    logic          disp_ovf;

    // host bus port
    logic          bus_stb;
    logic          bus_rnw;
    logic [0:AW-1] bus_addr;
    logic [0:DW-1] bus_wdata;
    logic [0:DW-1] bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    // video RAM port
    logic          ram_en;
    logic          ram_we;
    logic [0:AW-1] ram_addr;
    logic [0:DW-1] ram_wdata;
    logic [0:DW-1] ram_rdata;

    modport master (
        output disp_stb, disp_addr,
        output bus_stb, bus_rnw, bus_addr, bus_wdata,
        output ram_rdata,
        input  disp_data, disp_valid, disp_ovf,
        input  bus_rdata, bus_ack, bus_err,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  disp_stb, disp_addr,
        input  bus_stb, bus_rnw, bus_addr, bus_wdata,
        input  ram_rdata,
        output disp_data, disp_valid, disp_ovf,
        output bus_rdata, bus_ack, bus_err,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vga_ram_arbiter.sv
// Purpose : arbitrates a single-port video RAM between display fetches and host-bus accesses.
// Latency : strobe at edge E0, grant at E1, response pulse in the cycle after E3; one access per 2 cycles.
// Backpressure: one-deep pending buffer per requester; a strobe hitting a busy buffer is dropped and flagged.
//
// Port summary
//   Bus2IP_Clk   : single clock, all state on its rising edge
//   Bus2IP_Reset : asynchronous, active-high reset of all state and outputs
//   io           : display / bus / RAM signal bundle (vga_ram_arbiter_if.slave)
// Parameters: AW address width, DW data width, MAX_WAIT bus starvation limit in cycles.
`timescale 1ns/1ps
module vga_ram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic                Bus2IP_Clk,
    input  logic                Bus2IP_Reset,
    vga_ram_arbiter_if.slave    io
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    // pending buffers
    logic          r_disp_pend;
    logic [0:AW-1] r_disp_addr;
    logic          r_bus_pend;
    logic          r_bus_rnw;
    logic [0:AW-1] r_bus_addr;
    logic [0:DW-1] r_bus_wdata;

    // starvation counter and grant record for the access in flight
    logic [WW-1:0] r_wait_cnt;
    logic          r_gnt_bus;
    logic          r_gnt_rnw;

    // registered RAM drive
    logic          r_ram_en;
    logic          r_ram_we;
    logic [0:AW-1] r_ram_addr;
    logic [0:DW-1] r_ram_wdata;

    // registered responses
    logic [0:DW-1] r_disp_data;
    logic          r_disp_valid;
    logic          r_disp_ovf;
    logic [0:DW-1] r_bus_rdata;
    logic          r_bus_ack;
    logic          r_bus_err;

    // grant decode
    logic          w_grant;
    logic          w_grant_bus;
    logic          w_disp_gnt;
    logic          w_bus_gnt;
    logic          w_bus_starved;
    logic          w_disp_take;
    logic          w_bus_take;

    assign w_bus_starved = (r_wait_cnt >= WAIT_LIMIT);
    assign w_disp_gnt    = w_grant && !w_grant_bus;
    assign w_bus_gnt     = w_grant &&  w_grant_bus;

    // A buffer accepts a new strobe when empty, or when its current entry
    // is being granted on this same edge (the entry moves into the RAM stage).
    assign w_disp_take   = io.disp_stb && (!r_disp_pend || w_disp_gnt);
    assign w_bus_take    = io.bus_stb  && (!r_bus_pend  || w_bus_gnt);

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grants are only issued on the edge leaving IDLE or CAPTURE, so a new
    // access can never start while another sits in ACCESS.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_bus  = 1'b0;
        case (r_state)
            S_IDLE, S_CAPTURE: begin
                if (r_disp_pend || r_bus_pend) begin
                    w_next_state = S_ACCESS;
                    w_grant      = 1'b1;
                    // display has priority unless the bus has waited too long
                    w_grant_bus  = r_bus_pend && (!r_disp_pend || w_bus_starved);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_next_state = S_CAPTURE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Pending buffers
    //------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_disp_pend <= 1'b0;
            r_disp_addr <= '0;
            r_disp_ovf  <= 1'b0;
        end else begin
            if (w_disp_take) begin
                r_disp_pend <= 1'b1;
                r_disp_addr <= io.disp_addr;
            end else if (w_disp_gnt) begin
                r_disp_pend <= 1'b0;
            end
            r_disp_ovf <= io.disp_stb && !w_disp_take;
        end
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_bus_pend  <= 1'b0;
            r_bus_rnw   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_bus_take) begin
                r_bus_pend  <= 1'b1;
                r_bus_rnw   <= io.bus_rnw;
                r_bus_addr  <= io.bus_addr;
                r_bus_wdata <= io.bus_wdata;
            end else if (w_bus_gnt) begin
                r_bus_pend  <= 1'b0;
            end
            r_bus_err <= io.bus_stb && !w_bus_take;
        end
    end

    // Counts every cycle the bus entry waits, saturating at the limit.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_wait_cnt <= '0;
        end else if (w_bus_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_bus_pend && !w_bus_starved) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    //------------------------------------------------------------------
    // RAM drive: registered so the RAM sees clean signals for the whole
    // ACCESS cycle.
    //------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_gnt_bus   <= 1'b0;
            r_gnt_rnw   <= 1'b0;
        end else begin
            r_ram_en <= w_grant;
            r_ram_we <= w_bus_gnt && !r_bus_rnw;
            if (w_grant) begin
                r_gnt_bus  <= w_grant_bus;
                r_gnt_rnw  <= r_bus_rnw;
                r_ram_addr <= w_grant_bus ? r_bus_addr : r_disp_addr;
                if (w_bus_gnt && !r_bus_rnw) begin
                    r_ram_wdata <= r_bus_wdata;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Responses: RAM data is valid during CAPTURE and is registered at its
    // end; a bus write acks at the same point without touching bus_rdata.
    // Reset returns the FSM to IDLE, so an interrupted access never
    // reaches CAPTURE and never answers.
    //------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_bus_rdata  <= '0;
            r_bus_ack    <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            r_bus_ack    <= 1'b0;
            if (r_state == S_CAPTURE) begin
                if (r_gnt_bus) begin
                    r_bus_ack <= 1'b1;
                    if (r_gnt_rnw) begin
                        r_bus_rdata <= io.ram_rdata;
                    end
                end else begin
                    r_disp_valid <= 1'b1;
                    r_disp_data  <= io.ram_rdata;
                end
            end
        end
    end

    assign io.ram_en     = r_ram_en;
    assign io.ram_we     = r_ram_we;
    assign io.ram_addr   = r_ram_addr;
    assign io.ram_wdata  = r_ram_wdata;
    assign io.disp_data  = r_disp_data;
    assign io.disp_valid = r_disp_valid;
    assign io.disp_ovf   = r_disp_ovf;
    assign io.bus_rdata  = r_bus_rdata;
    assign io.bus_ack    = r_bus_ack;
    assign io.bus_err    = r_bus_err;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Purpose : directed checks of the video RAM arbiter against hand-computed cycle timelines.
// Latency : n/a (bench).
// Backpressure: n/a (bench); the RAM model answers one cycle after ram_en.
`timescale 1ns/1ps
module tb_vga_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    // RAM model: unwritten locations read as (low address byte ^ 0x3C)
    logic [7:0] mem     [0:4095];
    logic       mem_vld [0:4095];

    vga_ram_arbiter_if #(.AW(AW), .DW(DW)) io ();

    vga_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(16)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .io           (io.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem_vld[i] <= 1'b0;
        end else if (io.ram_en) begin
            if (io.ram_we) begin
                mem[io.ram_addr]     <= io.ram_wdata;
                mem_vld[io.ram_addr] <= 1'b1;
            end
            io.ram_rdata <= mem_vld[io.ram_addr] ? mem[io.ram_addr] : (io.ram_addr[4:11] ^ 8'h3C);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({io.ram_en, io.ram_we, io.ram_addr, io.ram_wdata, io.disp_data, io.disp_valid,
             io.disp_ovf, io.bus_rdata, io.bus_ack, io.bus_err} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got en=%b we=%b addr=%h wd=%h dd=%h dv=%b ovf=%b rd=%h ack=%b err=%b want all 0",
                     io.ram_en, io.ram_we, io.ram_addr, io.ram_wdata, io.disp_data, io.disp_valid,
                     io.disp_ovf, io.bus_rdata, io.bus_ack, io.bus_err);
        end
        rst = 1'b0;
        mem_clr = 1'b0;
        idle(2);
        vectors++;
        if ({io.ram_en, io.bus_ack, io.disp_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release_idle got en/ack/dv=%b want 000", {io.ram_en, io.bus_ack, io.disp_valid});
        end
    endtask

    task automatic test_bus_write;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b0; io.bus_addr = 12'h010; io.bus_wdata = 8'hA5;
        @(negedge clk); // after E0
        io.bus_stb = 1'b0;
        vectors++;
        if (io.ram_en !== 1'b0) begin miscompares++; $display("FAIL wr_e0_en got %b want 0", io.ram_en); end
        @(negedge clk); // after E1: ACCESS
        vectors++;
        if ({io.ram_en, io.ram_we} !== 2'b11) begin miscompares++; $display("FAIL wr_en_we got %b want 11", {io.ram_en, io.ram_we}); end
        vectors++;
        if (io.ram_addr !== 12'h010) begin miscompares++; $display("FAIL wr_addr got %h want 010", io.ram_addr); end
        vectors++;
        if (io.ram_wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_wdata got %h want a5", io.ram_wdata); end
        @(negedge clk); // after E2: CAPTURE
        vectors++;
        if ({io.ram_en, io.ram_we, io.bus_ack} !== 3'b000) begin
            miscompares++; $display("FAIL wr_capture got en/we/ack=%b want 000", {io.ram_en, io.ram_we, io.bus_ack});
        end
        @(negedge clk); // after E3
        vectors++;
        if ({io.bus_ack, io.disp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL wr_ack got ack/dv=%b want 10", {io.bus_ack, io.disp_valid});
        end
        vectors++;
        if (io.bus_rdata !== 8'h00) begin miscompares++; $display("FAIL wr_rdata_held got %h want 00", io.bus_rdata); end
        @(negedge clk); // after E4
        vectors++;
        if (io.bus_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_pulse got %b want 0", io.bus_ack); end
        idle(2);
    endtask

    task automatic test_bus_read;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b1; io.bus_addr = 12'h010; io.bus_wdata = 8'hFF;
        @(negedge clk);
        io.bus_stb = 1'b0;
        @(negedge clk); // after E1
        vectors++;
        if ({io.ram_en, io.ram_we} !== 2'b10 || io.ram_addr !== 12'h010) begin
            miscompares++; $display("FAIL rd_access got en/we=%b addr=%h want 10 010", {io.ram_en, io.ram_we}, io.ram_addr);
        end
        idle(2); // after E3
        vectors++;
        if ({io.bus_ack, io.disp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL rd_ack got ack/dv=%b want 10", {io.bus_ack, io.disp_valid});
        end
        vectors++;
        if (io.bus_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_data got %h want a5", io.bus_rdata); end
        @(negedge clk);
        vectors++;
        if ({io.bus_ack, io.disp_valid} !== 2'b00) begin
            miscompares++; $display("FAIL rd_after got ack/dv=%b want 00", {io.bus_ack, io.disp_valid});
        end
        idle(2);
    endtask

    task automatic test_simultaneous;
        io.disp_stb = 1'b1; io.disp_addr = 12'h100;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b1; io.bus_addr = 12'h010;
        @(negedge clk);
        io.disp_stb = 1'b0; io.bus_stb = 1'b0;
        @(negedge clk); // after E1: display granted
        vectors++;
        if (io.ram_en !== 1'b1 || io.ram_addr !== 12'h100) begin
            miscompares++; $display("FAIL sim_disp_first got en=%b addr=%h want 1 100", io.ram_en, io.ram_addr);
        end
        @(negedge clk); // after E2
        vectors++;
        if (io.ram_en !== 1'b0) begin miscompares++; $display("FAIL sim_gap got en=%b want 0", io.ram_en); end
        @(negedge clk); // after E3: bus granted, display answers
        vectors++;
        if (io.ram_en !== 1'b1 || io.ram_addr !== 12'h010 || io.ram_we !== 1'b0) begin
            miscompares++; $display("FAIL sim_bus_second got en=%b we=%b addr=%h want 1 0 010", io.ram_en, io.ram_we, io.ram_addr);
        end
        vectors++;
        if (io.disp_valid !== 1'b1 || io.disp_data !== 8'h3C) begin
            miscompares++; $display("FAIL sim_disp_data got dv=%b data=%h want 1 3c", io.disp_valid, io.disp_data);
        end
        idle(2); // after E5
        vectors++;
        if (io.bus_ack !== 1'b1 || io.bus_rdata !== 8'hA5 || io.disp_valid !== 1'b0) begin
            miscompares++; $display("FAIL sim_bus_ack got ack=%b rd=%h dv=%b want 1 a5 0", io.bus_ack, io.bus_rdata, io.disp_valid);
        end
        idle(2);
    endtask

    task automatic test_disp_overflow;
        int seen;
        seen = 0;
        io.disp_stb = 1'b1; io.disp_addr = 12'h102;
        @(negedge clk); // after E0
        io.disp_addr = 12'h103; // sampled on the grant edge -> accepted
        @(negedge clk); // after E1
        io.disp_addr = 12'h104; // buffer busy, not granted -> dropped
        vectors++;
        if (io.ram_addr !== 12'h102 || io.disp_ovf !== 1'b0) begin
            miscompares++; $display("FAIL dovf_first got addr=%h ovf=%b want 102 0", io.ram_addr, io.disp_ovf);
        end
        @(negedge clk); // after E2
        io.disp_stb = 1'b0;
        vectors++;
        if (io.disp_ovf !== 1'b1) begin miscompares++; $display("FAIL dovf_pulse got %b want 1", io.disp_ovf); end
        @(negedge clk); // after E3
        vectors++;
        if (io.ram_en !== 1'b1 || io.ram_addr !== 12'h103 || io.disp_ovf !== 1'b0) begin
            miscompares++; $display("FAIL dovf_second got en=%b addr=%h ovf=%b want 1 103 0", io.ram_en, io.ram_addr, io.disp_ovf);
        end
        vectors++;
        if (io.disp_valid !== 1'b1 || io.disp_data !== 8'h3E) begin
            miscompares++; $display("FAIL dovf_data1 got dv=%b data=%h want 1 3e", io.disp_valid, io.disp_data);
        end
        idle(2); // after E5
        vectors++;
        if (io.disp_valid !== 1'b1 || io.disp_data !== 8'h3F) begin
            miscompares++; $display("FAIL dovf_data2 got dv=%b data=%h want 1 3f", io.disp_valid, io.disp_data);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (io.ram_en) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL dovf_dropped_access got %0d accesses want 0", seen); end
    endtask

    task automatic test_bus_overflow;
        int errs, bad, wr_k, ack_k;
        logic [7:0] wr_dat;
        errs = 0; bad = 0; wr_k = -1; ack_k = -1; wr_dat = 8'h00;
        io.disp_stb = 1'b1; io.disp_addr = 12'h101;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b0; io.bus_addr = 12'h030; io.bus_wdata = 8'h11;
        @(negedge clk); // after E0
        io.disp_stb = 1'b0;
        io.bus_addr = 12'h031; io.bus_wdata = 8'h22;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk); // after Ek
            io.bus_stb = 1'b0;
            if (io.bus_err) errs++;
            if (io.ram_en && io.ram_addr == 12'h031) bad++;
            if (io.ram_en && io.ram_we && io.ram_addr == 12'h030 && wr_k < 0) begin
                wr_k = k; wr_dat = io.ram_wdata;
            end
            if (io.bus_ack && ack_k < 0) ack_k = k;
        end
        vectors++;
        if (errs !== 1) begin miscompares++; $display("FAIL bovf_err_count got %0d want 1", errs); end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL bovf_second_accessed got %0d want 0", bad); end
        vectors++;
        if (wr_k !== 3 || wr_dat !== 8'h11) begin
            miscompares++; $display("FAIL bovf_first_write got edge=%0d data=%h want 3 11", wr_k, wr_dat);
        end
        vectors++;
        if (ack_k !== 5) begin miscompares++; $display("FAIL bovf_ack_edge got %0d want 5", ack_k); end
        idle(2);
    endtask

    task automatic test_starvation;
        int bus_k, disp_before, disp_after_k, ovfs, ack_k, dvs;
        logic [7:0] ack_dat;
        bus_k = -1; disp_before = 0; disp_after_k = -1; ovfs = 0; ack_k = -1; dvs = 0; ack_dat = 8'h00;
        io.disp_stb = 1'b1; io.disp_addr = 12'h200;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b1; io.bus_addr = 12'h010;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); // after Ek
            if (io.ram_en) begin
                if (io.ram_addr == 12'h010) begin
                    if (bus_k < 0) bus_k = k;
                end else if (bus_k < 0) begin
                    disp_before++;
                end else if (disp_after_k < 0) begin
                    disp_after_k = k;
                end
            end
            if (io.disp_ovf) ovfs++;
            if (io.disp_valid) dvs++;
            if (io.bus_ack && ack_k < 0) begin ack_k = k; ack_dat = io.bus_rdata; end
            // new display strobe lands on every display grant edge E1..E15
            io.bus_stb  = 1'b0;
            io.disp_stb = ((k % 2) == 0) && (k <= 14);
            io.disp_addr = 12'h200 + 12'(k + 1);
        end
        io.disp_stb = 1'b0;
        vectors++;
        if (bus_k !== 17) begin miscompares++; $display("FAIL starve_bus_grant got edge %0d want 17", bus_k); end
        vectors++;
        if (disp_before !== 8) begin miscompares++; $display("FAIL starve_disp_before got %0d want 8", disp_before); end
        vectors++;
        if (disp_after_k !== 19) begin miscompares++; $display("FAIL starve_disp_resume got edge %0d want 19", disp_after_k); end
        vectors++;
        if (ack_k !== 19 || ack_dat !== 8'hA5) begin
            miscompares++; $display("FAIL starve_bus_ack got edge=%0d data=%h want 19 a5", ack_k, ack_dat);
        end
        vectors++;
        if (ovfs !== 0 || dvs !== 9) begin
            miscompares++; $display("FAIL starve_disp_counts got ovf=%0d valid=%0d want 0 9", ovfs, dvs);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_access;
        int seen;
        seen = 0;
        io.bus_stb = 1'b1; io.bus_rnw = 1'b0; io.bus_addr = 12'h020; io.bus_wdata = 8'h5A;
        @(negedge clk);
        io.bus_stb = 1'b0;
        @(negedge clk); // after E1: ACCESS
        vectors++;
        if (io.ram_en !== 1'b1) begin miscompares++; $display("FAIL mid_in_access got en=%b want 1", io.ram_en); end
        rst = 1'b1;
        #1;
        vectors++;
        if ({io.ram_en, io.ram_we, io.ram_addr, io.ram_wdata, io.disp_data, io.disp_valid,
             io.disp_ovf, io.bus_rdata, io.bus_ack, io.bus_err} !== 42'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got en=%b we=%b addr=%h wd=%h dd=%h rd=%h want all 0",
                     io.ram_en, io.ram_we, io.ram_addr, io.ram_wdata, io.disp_data, io.bus_rdata);
        end
        #19;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (io.bus_ack || io.disp_valid || io.ram_en) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL mid_no_response got %0d active cycles want 0", seen); end
    endtask

    initial begin
        io.disp_stb = 1'b0; io.disp_addr = '0;
        io.bus_stb = 1'b0; io.bus_rnw = 1'b0; io.bus_addr = '0; io.bus_wdata = '0;
        test_reset;
        test_bus_write;
        test_bus_read;
        test_simultaneous;
        test_disp_overflow;
        test_bus_overflow;
        test_starvation;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
